// File: rtl/ibuf_loader_if.sv
// Stream-in and buffer-write-port interfaces used by the input buffer loader.
// The stream carries one word per valid/ready beat; the write port is a one-cycle strobe with no backpressure.

interface ibuf_stream_if #(
    parameter int DW = 64
) ();
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

interface ibuf_wr_if #(
    parameter int AW = 11,
    parameter int DW = 64
) ();
    logic          mem_write_req;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_write_data;

    modport master (output mem_write_req, output mem_write_addr, output mem_write_data);
    modport slave  (input  mem_write_req, input  mem_write_addr, input  mem_write_data);
endinterface

// File: rtl/ibuf_loader.sv
// Input buffer loader: turns a valid/ready word stream into sequential buffer writes from a base address.
// Define IBUF_LOADER_PERF_EN to build the stall_cycles starvation counter; otherwise it is tied to 0.

module ibuf_loader #(
    parameter int MEM_DATA_WIDTH = 64,
    parameter int BUF_ADDR_WIDTH = 10,
    parameter int BUF_ID_W       = 1,
    parameter int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W,
    parameter int CNT_W          = MEM_ADDR_WIDTH + 1,
    parameter int PERF_W         = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_W-1:0]          num_words,
    input  logic                      abort,
    ibuf_stream_if.slave              in_s,
    ibuf_wr_if.master                 wr,
    output logic                      busy,
    output logic                      done,
    output logic [PERF_W-1:0]         stall_cycles
);

    // state | meaning
    // IDLE  | waiting for start
    // LOAD  | accepting stream words, one write per beat
    // DONE  | one-cycle completion, done pulses here
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                    state;
    logic [MEM_ADDR_WIDTH-1:0] cur_addr;
    logic [CNT_W-1:0]          remaining;
    logic                      ready;
    logic                      beat;
    logic                      start_ok;

    assign ready         = (state == LOAD) && (remaining != '0) && !abort;
    assign in_s.in_ready = ready;
    assign beat          = in_s.in_valid && ready;
    assign start_ok      = (state == IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            cur_addr          <= '0;
            remaining         <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            wr.mem_write_req  <= 1'b0;
            wr.mem_write_addr <= '0;
            wr.mem_write_data <= '0;
        end else begin
            wr.mem_write_req <= 1'b0;
            done             <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr  <= base_addr;
                        remaining <= num_words;
                        busy      <= 1'b1;
                        if (num_words != '0) begin
                            state <= LOAD;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (beat) begin
                        wr.mem_write_req  <= 1'b1;
                        wr.mem_write_addr <= cur_addr;
                        wr.mem_write_data <= in_s.in_data;
                        cur_addr          <= cur_addr + MEM_ADDR_WIDTH'(1);
                        remaining         <= remaining - CNT_W'(1);
                        // last word: completion pulse lines up with its write
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IBUF_LOADER_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
        end else if ((state == LOAD) && (remaining != '0) && !in_s.in_valid
                     && (stall_cycles != {PERF_W{1'b1}})) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ibuf_loader.sv
// Directed bench for ibuf_loader: burst, wrap with gaps, zero-length, abort, start-in-load and mid-load reset.
// Expected addresses, data and pulse timing are hand-derived per scenario.

module tb_ibuf_loader;

    localparam int DW = 64;
    localparam int AW = 11;
    localparam int CW = 12;
    localparam int PW = 16;
`ifdef IBUF_LOADER_PERF_EN
    localparam int EXP_STALL_B = 3;
`else
    localparam int EXP_STALL_B = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_words = '0;
    logic          busy;
    logic          done;
    logic [PW-1:0] stall_cycles;

    ibuf_stream_if #(.DW(DW))         s_if ();
    ibuf_wr_if     #(.AW(AW), .DW(DW)) w_if ();

    ibuf_loader #(
        .MEM_DATA_WIDTH(DW),
        .BUF_ADDR_WIDTH(10),
        .BUF_ID_W      (1),
        .PERF_W        (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .num_words   (num_words),
        .abort       (abort),
        .in_s        (s_if.slave),
        .wr          (w_if.master),
        .busy        (busy),
        .done        (done),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];

    always @(negedge clk) begin
        if (reset) begin
            if (w_if.mem_write_req) begin
                log_addr.push_back(w_if.mem_write_addr);
                log_data.push_back(w_if.mem_write_data);
            end
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] pat(input int k);
        return 64'hA5A5_0000_0000_0000 + 64'(k);
    endfunction

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    // leaves the bench in the first LOAD cycle (or DONE when n == 0)
    task automatic start_load(input logic [AW-1:0] b, input logic [CW-1:0] n);
        tick();
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        tick();
        start = 1'b0;
    endtask

    task automatic check_log(input string tag, input int n, input logic [AW-1:0] a0);
        logic [AW-1:0] ea;
        chk({tag, "_cnt"}, 64'(log_addr.size()), 64'(n));
        for (int i = 0; i < n && i < log_addr.size(); i++) begin
            ea = a0 + AW'(i);
            chk({tag, "_addr"}, 64'(log_addr[i]), 64'(ea));
            chk({tag, "_data"}, log_data[i], pat(i));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int snap;
        s_if.in_valid = 1'b0;
        s_if.in_data  = '0;

        // reset state
        smp();
        chk("rst_req",   64'(w_if.mem_write_req),  64'd0);
        chk("rst_addr",  64'(w_if.mem_write_addr), 64'd0);
        chk("rst_data",  w_if.mem_write_data,      64'd0);
        chk("rst_busy",  64'(busy),                64'd0);
        chk("rst_done",  64'(done),                64'd0);
        chk("rst_ready", 64'(s_if.in_ready),       64'd0);
        chk("rst_stall", 64'(stall_cycles),        64'd0);
        tick();
        reset = 1'b1;

        // back-to-back burst of 4 from 0x010
        clear_log();
        start_load(11'h010, 12'd4);
        s_if.in_valid = 1'b1;
        s_if.in_data  = pat(0);
        smp();
        chk("a_ready", 64'(s_if.in_ready), 64'd1);
        chk("a_busy",  64'(busy),          64'd1);
        chk("a_req0",  64'(w_if.mem_write_req), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) s_if.in_data = pat(i + 1);
            else       s_if.in_valid = 1'b0;
            smp();
            chk("a_req",  64'(w_if.mem_write_req),  64'd1);
            chk("a_addr", 64'(w_if.mem_write_addr), 64'(11'h010 + 11'(i)));
            chk("a_data", w_if.mem_write_data,      pat(i));
            chk("a_done", 64'(done),                64'(i == 3));
            chk("a_busyw", 64'(busy),               64'd1);
        end
        tick();
        smp();
        chk("a_busy_end", 64'(busy),               64'd0);
        chk("a_req_end",  64'(w_if.mem_write_req), 64'd0);
        chk("a_done_end", 64'(done),               64'd0);

        // wrap across 0x7FF with alternating valid
        clear_log();
        d0 = done_cnt;
        start_load(11'h7FE, 12'd4);
        for (int c = 0; c < 8; c++) begin
            s_if.in_valid = (c % 2 == 0) && (c < 7);
            s_if.in_data  = pat(c / 2);
            tick();
        end
        s_if.in_valid = 1'b0;
        smp();
        check_log("b", 4, 11'h7FE);
        chk("b_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("b_busy",     64'(busy),          64'd0);
        chk("b_stall",    64'(stall_cycles),  64'(EXP_STALL_B));

        // zero-length load, second start in DONE ignored
        clear_log();
        d0 = done_cnt;
        s_if.in_valid = 1'b1;
        start_load(11'h123, 12'd0);
        start     = 1'b1;
        base_addr = 11'h055;
        num_words = 12'd5;
        smp();
        chk("c_done",  64'(done),               64'd1);
        chk("c_busy",  64'(busy),               64'd1);
        chk("c_ready", 64'(s_if.in_ready),      64'd0);
        chk("c_req",   64'(w_if.mem_write_req), 64'd0);
        tick();
        start = 1'b0;
        smp();
        chk("c_busy_idle", 64'(busy),          64'd0);
        chk("c_done_idle", 64'(done),          64'd0);
        chk("c_ready_idle", 64'(s_if.in_ready), 64'd0);
        tick();
        smp();
        chk("c_busy_later", 64'(busy), 64'd0);
        chk("c_writes",   64'(log_addr.size()), 64'd0);
        chk("c_done_cnt", 64'(done_cnt - d0),   64'd1);
        chk("c_stall",    64'(stall_cycles),    64'd0);
        s_if.in_valid = 1'b0;

        // abort after 5 of 8 beats, then a fresh load
        clear_log();
        d0 = done_cnt;
        start_load(11'h100, 12'd8);
        s_if.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_if.in_data = pat(i);
            tick();
        end
        s_if.in_data = pat(5);
        abort = 1'b1;
        smp();
        chk("d_ready", 64'(s_if.in_ready),      64'd0);
        chk("d_req",   64'(w_if.mem_write_req), 64'd1);
        chk("d_addr",  64'(w_if.mem_write_addr), 64'h104);
        chk("d_busy",  64'(busy),               64'd1);
        tick();
        abort = 1'b0;
        smp();
        chk("d_req_after",  64'(w_if.mem_write_req), 64'd0);
        chk("d_busy_after", 64'(busy),               64'd0);
        chk("d_ready_after", 64'(s_if.in_ready),     64'd0);
        check_log("d", 5, 11'h100);
        chk("d_no_done", 64'(done_cnt - d0), 64'd0);
        clear_log();
        start_load(11'h200, 12'd2);
        s_if.in_data = pat(0);
        tick();
        s_if.in_data = pat(1);
        tick();
        s_if.in_valid = 1'b0;
        tick();
        tick();
        check_log("d2", 2, 11'h200);
        chk("d2_done_cnt", 64'(done_cnt - d0), 64'd1);

        // start during LOAD is ignored
        clear_log();
        d0 = done_cnt;
        start_load(11'h040, 12'd3);
        s_if.in_valid = 1'b1;
        s_if.in_data  = pat(0);
        tick();
        s_if.in_data = pat(1);
        start     = 1'b1;
        base_addr = 11'h300;
        num_words = 12'd1;
        tick();
        start = 1'b0;
        s_if.in_data = pat(2);
        tick();
        s_if.in_valid = 1'b0;
        tick();
        tick();
        check_log("e", 3, 11'h040);
        chk("e_done_cnt", 64'(done_cnt - d0), 64'd1);

        // asynchronous reset after 3 of 8 beats
        clear_log();
        d0 = done_cnt;
        start_load(11'h020, 12'd8);
        s_if.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_if.in_data = pat(i);
            tick();
        end
        #2;
        reset = 1'b0;
        snap = log_addr.size();
        #1;
        chk("r_req",   64'(w_if.mem_write_req),  64'd0);
        chk("r_addr",  64'(w_if.mem_write_addr), 64'd0);
        chk("r_data",  w_if.mem_write_data,      64'd0);
        chk("r_busy",  64'(busy),                64'd0);
        chk("r_done",  64'(done),                64'd0);
        chk("r_ready", 64'(s_if.in_ready),       64'd0);
        chk("r_stall", 64'(stall_cycles),        64'd0);
        tick();
        tick();
        reset = 1'b1;
        smp();
        chk("r_ready_rel", 64'(s_if.in_ready), 64'd0);
        for (int i = 0; i < 10; i++) tick();
        smp();
        chk("r_busy_rel", 64'(busy),                 64'd0);
        chk("r_writes",   64'(log_addr.size() - snap), 64'd0);
        chk("r_no_done",  64'(done_cnt - d0),        64'd0);
        s_if.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ibuf_loader.md
Name: ibuf_loader

Overview:
- Upstream write-side feeder for the input buffer.
- Takes a valid/ready stream of MEM_DATA_WIDTH words from the memory interface.
- Converts it into the buffer's single-cycle write strobe (mem_write_req/addr/data), running sequential addresses from a programmed base.
- Controlled by a start/abort/done command interface from the layer controller.

Parameters:
- MEM_DATA_WIDTH, 64: width of one streamed word and of mem_write_data.
- BUF_ADDR_WIDTH, 10: per-bank address width of the input buffer.
- BUF_ID_W, 1: bank-select bits appended below the bank address.
- MEM_ADDR_WIDTH, BUF_ADDR_WIDTH+BUF_ID_W: width of the write address and base address.
- CNT_W, MEM_ADDR_WIDTH+1: width of the word-count field.
- PERF_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command pulse; accepted only in IDLE.
- base_addr  in  MEM_ADDR_WIDTH  first write address; sampled on accepted start.
- num_words  in  CNT_W  number of words to load; sampled on accepted start.
- abort  in  1  synchronous cancel of a load in progress.
- in_valid  in  1  stream word valid.
- in_data  in  MEM_DATA_WIDTH  stream word.
- in_ready  out  1  loader can accept a word.
- mem_write_req  out  1  write strobe to the input buffer.
- mem_write_addr  out  MEM_ADDR_WIDTH  write address.
- mem_write_data  out  MEM_DATA_WIDTH  write data.
- busy  out  1  high in LOAD and DONE.
- done  out  1  one-cycle completion pulse.
- stall_cycles  out  PERF_W  starvation counter (see Optional Feature).

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; all outputs 0, including the address, data and counter registers. A reset in the middle of a load discards it: no done, no further writes.
- States:
  - IDLE -> LOAD on start when num_words!=0; base_addr and num_words are latched into cur_addr and remaining.
  - IDLE -> DONE on start when num_words==0; no writes are issued.
  - LOAD -> DONE in the cycle after the beat that takes remaining to 0.
  - LOAD -> IDLE on abort.
  - DONE -> IDLE unconditionally after one cycle.
- start outside IDLE is ignored, including in the DONE cycle. base_addr and num_words are don't-care when start is not accepted.
- in_ready = (state==LOAD) && (remaining!=0) && !abort. This is the only combinational output; all others are registered.
- Beat: in_valid && in_ready at edge T.
  - At T+1: mem_write_req=1, mem_write_addr=cur_addr (pre-increment value), mem_write_data=in_data from T.
  - Write latency is exactly 1 cycle.
  - cur_addr increments by 1, wrapping modulo 2^MEM_ADDR_WIDTH. remaining decrements by 1.
- mem_write_req is 0 in every cycle that does not follow a beat. mem_write_addr and mem_write_data hold their last values when not writing.
- Back-to-back beats produce back-to-back writes at one word per cycle. The buffer write port has no backpressure; the loader never stalls its write output.
- Completion:
  - The last beat at T gives the last write at T+1, the DONE state at T+1, and done=1 at T+1 (same cycle as the last write).
  - State is IDLE at T+2.
  - busy=1 from the cycle after start through the DONE cycle.
- num_words larger than 2^MEM_ADDR_WIDTH is legal: addresses wrap and earlier entries are overwritten.
- Abort while in LOAD:
  - in_ready is forced low in the abort cycle; no beat is taken.
  - State becomes IDLE at the next edge, with no done pulse.
  - A write already registered from the previous cycle's beat still completes.
- Abort in IDLE or DONE is ignored.
- in_valid while in_ready=0 is ignored; the word is not consumed.

Optional Feature:
- Macro: IBUF_LOADER_PERF_EN.
- Defined:
  - stall_cycles counts cycles with state==LOAD && remaining!=0 && !in_valid.
  - Saturates at 2^PERF_W-1.
  - Cleared to 0 on accepted start; holds its value in IDLE and DONE.
- Not defined: the counter logic is absent and stall_cycles is tied to 0.

Test Plan:
- Reset low mid-load (after 3 of 8 beats) -> all outputs 0 immediately; after release, state IDLE; no done pulse ever observed for that load.
- start, base_addr=0x010, num_words=4, in_valid held high -> writes in 4 consecutive cycles to 0x010..0x013 with matching data; done coincides with the 0x013 write; busy drops the following cycle.
- base_addr=0x7FE (11-bit), num_words=4, in_valid toggling 1,0,1,0,... -> writes to 0x7FE, 0x7FF, 0x000, 0x001, one per accepted beat; with IBUF_LOADER_PERF_EN, stall_cycles=3.
- start with num_words=0 -> no mem_write_req, no in_ready; done=1 on the cycle after start; a second start during that DONE cycle is ignored.
- num_words=8, abort asserted after beat 5 -> in_ready low in the abort cycle; exactly 5 writes; no done; IDLE next cycle; a new start is then accepted normally.
- start pulsed during LOAD with a different base_addr -> ignored; addresses continue the original sequence.
